// File: rtl/rx_word_fifo.sv
// Purpose : first-word-fall-through buffer for 16-bit words from the receiver to the SPI master.
// Latency : a word pushed at an edge is on out_data (out_valid=1) right after that edge.
// Backpressure: none on the input side; a push into a full FIFO is dropped and flagged in overflow.
// Optional : define RX_FIFO_DROP_COUNT_EN to add a saturating 8-bit drop_count output.
module rx_word_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  input  logic [15:0]           in_data,
  input  logic                  in_strobe,
  input  logic                  flush,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_accept,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
`ifdef RX_FIFO_DROP_COUNT_EN
  output logic [7:0]            drop_count,
`endif
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  // Word storage; deliberately not reset, only pointers and flags are.
  logic [15:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // A pop needs data present; a pop on an empty FIFO is simply ignored.
  assign do_pop  = out_accept && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = in_strobe && (!full || do_pop);
  assign do_drop = in_strobe && full && !do_pop;

  assign out_valid   = !empty;
  assign out_data    = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = (32'(level) >= AF_LEVEL);

  // Write the incoming word into the slot addressed by the write pointer.
  always_ff @(posedge mclk) begin
    if (do_push && !flush) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  // Advance pointers; flush wins over any push or pop in the same cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overflow flag: set on any dropped word, cleared only by reset or flush.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (do_drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef RX_FIFO_DROP_COUNT_EN
  // Count dropped words, holding at 255 rather than wrapping.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 8'd0;
    end else if (flush) begin
      drop_count <= 8'd0;
    end else if (do_drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/rx_word_fifo.md
RX_WORD_FIFO -- requirements
Module: rx_word_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving the buffer depth as 2^DEPTH_LOG2 16-bit words.
REQ-002 SHALL have parameter AF_LEVEL, default 12, giving the almost-full threshold in words.
REQ-003 mclk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  16  received word from the receiver stage.
REQ-006 in_strobe  input  1  one-cycle pulse marking in_data valid; there is no backpressure.
REQ-007 flush  input  1  synchronous clear, asserted while the receiver is disabled.
REQ-008 out_data  output  16  head word toward the SPI master, valid while out_valid=1.
REQ-009 out_valid  output  1  FIFO non-empty (level signal).
REQ-010 out_accept  input  1  one-cycle pop request from the SPI master.
REQ-011 level  output  DEPTH_LOG2+1  current word count.
REQ-012 almost_full  output  1  asserted when level >= AF_LEVEL.
REQ-013 overflow  output  1  sticky flag set when a word is dropped.

Function
REQ-014 SHALL be first-word-fall-through: a word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the FIFO was empty.
REQ-015 SHALL push when in_strobe=1 and level < depth; the write pointer increments modulo depth.
REQ-016 SHALL pop when out_accept=1 and out_valid=1; out_data SHALL present the next word after that edge.
REQ-017 SHALL ignore out_accept while out_valid=0, with no pointer or level change.
REQ-018 On simultaneous push and pop while non-empty, including full, SHALL accept both and leave level unchanged.
REQ-019 On simultaneous push and pop while empty, SHALL accept the push only; level becomes 1.
REQ-020 On in_strobe=1 while full with no pop, SHALL drop the word, set overflow, and leave FIFO contents and pointers unchanged.
REQ-021 Pointers SHALL be DEPTH_LOG2+1 bits wide; full/empty SHALL be decided by MSB/LSB pointer comparison; wrap-around SHALL be seamless.
REQ-022 level SHALL equal write pointer minus read pointer (modulo 2^(DEPTH_LOG2+1)) and SHALL never exceed depth.
REQ-023 flush=1 SHALL empty the FIFO and clear overflow at the next edge, taking priority over push and pop in the same cycle.
REQ-024 overflow SHALL clear only on reset or flush.
REQ-025 Storage SHALL be a register array with no reset; only pointers and flags are reset.

Reset
REQ-026 reset_n=0 SHALL immediately, asynchronously, force pointers to 0, out_valid=0, level=0, almost_full=0 and overflow=0.
REQ-027 out_data SHALL be don't-care while out_valid=0.
REQ-028 Reset mid-operation SHALL discard all buffered words.
REQ-029 The first push after reset_n rises SHALL behave as a push into an empty FIFO.

Configuration
REQ-030 With RX_FIFO_DROP_COUNT_EN defined, SHALL add output drop_count [7:0].
  - Increments once per dropped word.
  - Saturates at 255.
  - Clears on reset or flush.
REQ-031 Without RX_FIFO_DROP_COUNT_EN, drop_count SHALL be absent; all other behaviour is identical.

Verification
REQ-032 After reset, push 0x1234 with no pop -> out_valid=1 and out_data=0x1234 after that edge; level=1.
REQ-033 Push 16 words 0x0000..0x000F, then a 17th word 0xFFFF -> level=16, overflow=1, 0xFFFF absent; pops return 0x0000..0x000F in order.
REQ-034 Fill to 16, then push and pop in the same cycle -> level stays 16, no overflow, popped word is the oldest.
REQ-035 Push 12 words -> almost_full=1 on the edge of the 12th push; one pop -> almost_full=0.
REQ-036 Pulse out_accept on an empty FIFO -> no change; push+flush in the same cycle -> level=0, overflow=0.
REQ-037 With RX_FIFO_DROP_COUNT_EN, 300 pushes into a full FIFO -> drop_count=255; flush -> drop_count=0.
